// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank.
package opb_regbank_pkg;

  localparam int OPB_DW    = 32;
  localparam int OPB_BYTES = OPB_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } ack_state_e;

  // Bits needed to index n distinct words (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Byte-lane merge. be[0] selects the most significant byte, matching
  // OPB big-endian lane numbering once the bus is viewed as [31:0].
  function automatic logic [OPB_DW-1:0] be_merge(input logic [OPB_DW-1:0] old_v,
                                                 input logic [OPB_DW-1:0] new_v,
                                                 input logic [0:OPB_BYTES-1] be);
    logic [OPB_DW-1:0] r;
    r = old_v;
    for (int b = 0; b < OPB_BYTES; b++)
      if (be[b]) r[OPB_DW-1-8*b -: 8] = new_v[OPB_DW-1-8*b -: 8];
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave front end: window decode, request latch and the
// IDLE -> ACK -> HOLD handshake. Read data is only driven during ACK so
// the shared wired-OR data bus sees zero at all other times.
module opb_slave_ack_fsm
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01004000,
  parameter logic [31:0] C_HIGHADDR = 32'h010040FF,
  parameter int          C_NUM_REGS = 8,
  parameter int          IDX_W      = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            abus_i,
  input  logic [0:OPB_BYTES-1]   be_i,
  input  logic [31:0]            dbus_i,
  input  logic                   rnw_i,
  input  logic                   select_i,
  input  logic [31:0]            rdata_i,
  output logic                   ack_o,
  output logic                   rnw_o,
  output logic [0:OPB_BYTES-1]   be_o,
  output logic [31:0]            wdata_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   idx_vld_o,
  output logic [31:0]            sl_dbus_o,
  output logic                   sl_errack_o,
  output logic                   sl_retry_o,
  output logic                   sl_toutsup_o
);

  ack_state_e state_q, state_d;
  logic       hit;
  logic [29:0] word_idx;
  logic       in_rng;

  assign hit      = select_i && (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);
  assign word_idx = 30'((abus_i - C_BASEADDR) >> 2);
  // Index C_NUM_REGS is kept distinguishable (commit register); anything
  // beyond is acked but maps to nothing.
  assign in_rng   = (word_idx <= 30'(C_NUM_REGS));

  // Next-state: a hit is only accepted from IDLE; HOLD swallows select.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; async reset drops the ack in the same instant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Capture the request when it is accepted so the ACK cycle is self-contained.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rnw_o     <= 1'b0;
      be_o      <= '0;
      wdata_o   <= '0;
      idx_o     <= '0;
      idx_vld_o <= 1'b0;
    end else if (state_q == ST_IDLE && hit) begin
      rnw_o     <= rnw_i;
      be_o      <= be_i;
      wdata_o   <= dbus_i;
      idx_o     <= word_idx[IDX_W-1:0];
      idx_vld_o <= in_rng;
    end
  end

  assign ack_o        = (state_q == ST_ACK);
  assign sl_dbus_o    = (ack_o && rnw_o) ? rdata_i : '0;
  assign sl_errack_o  = 1'b0;
  assign sl_retry_o   = 1'b0;
  assign sl_toutsup_o = 1'b0;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Bank of C_NUM_REGS software-writable 32-bit registers exported in
// parallel to user logic, with readback and a one-cycle write strobe.
// Optional feature macro: OPB_REGBANK_SHADOW_EN -- writes go to shadow
// registers and a write to index C_NUM_REGS commits all of them at once.
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01004000,
  parameter logic [31:0] C_HIGHADDR   = 32'h010040FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 8,
  parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  output logic                         Sl_xferAck,
  output logic [C_NUM_REGS*32-1:0]     user_data_out,
  output logic [C_NUM_REGS-1:0]        user_wr_strb
);

  localparam int IDX_W = idx_width(C_NUM_REGS + 1);

  logic                 ack, rnw, idx_vld, wr_en;
  logic [0:OPB_BYTES-1] be;
  logic [31:0]          wdata, rdata;
  logic [IDX_W-1:0]     idx;
  logic [31:0]          user_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] strb_q;
  logic                 unused_seqaddr;

  // Bursts are not supported; sequential-address hint is ignored.
  assign unused_seqaddr = OPB_seqAddr;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .C_NUM_REGS (C_NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_fsm (
    .clk_i        (OPB_Clk),
    .rst_i        (OPB_Rst),
    .abus_i       (OPB_ABus),
    .be_i         (OPB_BE),
    .dbus_i       (OPB_DBus),
    .rnw_i        (OPB_RNW),
    .select_i     (OPB_select),
    .rdata_i      (rdata),
    .ack_o        (ack),
    .rnw_o        (rnw),
    .be_o         (be),
    .wdata_o      (wdata),
    .idx_o        (idx),
    .idx_vld_o    (idx_vld),
    .sl_dbus_o    (Sl_DBus),
    .sl_errack_o  (Sl_errAck),
    .sl_retry_o   (Sl_retry),
    .sl_toutsup_o (Sl_toutSup)
  );

  assign Sl_xferAck = ack;
  assign wr_en      = ack && !rnw && idx_vld;

`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0] shadow_q [C_NUM_REGS];
  logic [31:0] commit_cnt_q;
  logic        commit_wr;

  assign commit_wr = wr_en && (idx == IDX_W'(C_NUM_REGS));

  // Software writes land in the shadow copy only.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) shadow_q[i] <= C_RESET_VAL;
    end else if (wr_en) begin
      for (int i = 0; i < C_NUM_REGS; i++)
        if (idx == IDX_W'(i)) shadow_q[i] <= be_merge(shadow_q[i], wdata, be);
    end
  end

  // Commit copies every shadow to the user side in one edge and strobes all.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) user_q[i] <= C_RESET_VAL;
      strb_q       <= '0;
      commit_cnt_q <= '0;
    end else begin
      strb_q <= '0;
      if (commit_wr) begin
        for (int i = 0; i < C_NUM_REGS; i++) user_q[i] <= shadow_q[i];
        strb_q       <= '1;
        commit_cnt_q <= commit_cnt_q + 32'd1;
      end
    end
  end

  // Readback shows what software wrote (shadow) and the commit count.
  always_comb begin
    rdata = '0;
    if (idx_vld) begin
      for (int i = 0; i < C_NUM_REGS; i++)
        if (idx == IDX_W'(i)) rdata = shadow_q[i];
      if (idx == IDX_W'(C_NUM_REGS)) rdata = commit_cnt_q;
    end
  end
`else
  // Direct writes: merged byte lanes plus a strobe for the touched register.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) user_q[i] <= C_RESET_VAL;
      strb_q <= '0;
    end else begin
      strb_q <= '0;
      if (wr_en) begin
        for (int i = 0; i < C_NUM_REGS; i++)
          if (idx == IDX_W'(i)) begin
            user_q[i] <= be_merge(user_q[i], wdata, be);
            strb_q[i] <= 1'b1;
          end
      end
    end
  end

  // Readback of the live registers; unmapped indices read zero.
  always_comb begin
    rdata = '0;
    if (idx_vld)
      for (int i = 0; i < C_NUM_REGS; i++)
        if (idx == IDX_W'(i)) rdata = user_q[i];
  end
`endif

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_pack
    assign user_data_out[32*g +: 32] = user_q[g];
  end

  assign user_wr_strb = strb_q;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Directed bench for the OPB register bank; expected read data goes into a
// scoreboard queue when a transfer is issued and is popped on the ack.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01004000;
  localparam int          N    = 8;
  localparam logic [31:0] RV   = 32'hA0A00001;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [0:31]     abus = '0;
  logic [0:3]      be = '0;
  logic [0:31]     dbus = '0;
  logic            rnw = 1'b0, sel = 1'b0, seq = 1'b0;
  logic [0:31]     sl_dbus;
  logic            errack, retry, tout, xack;
  logic [N*32-1:0] udata;
  logic [N-1:0]    strb;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] sb [$];
  logic [31:0] model [N];   // user-visible value of each register
`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0] shadow_m [N];
`endif

  always #5 clk = ~clk;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (32'h010040FF),
    .C_NUM_REGS  (N),
    .C_RESET_VAL (RV)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst       (rst),
    .OPB_ABus      (abus),
    .OPB_BE        (be),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_errAck     (errack),
    .Sl_retry      (retry),
    .Sl_toutSup    (tout),
    .Sl_xferAck    (xack),
    .user_data_out (udata),
    .user_wr_strb  (strb)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*32-1:0] pack_model();
    logic [N*32-1:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = model[i];
    return r;
  endfunction

  // Issue one transfer; returns in the ack cycle (N+1) after checking it.
  task automatic xfer(input logic r, input int idx, input logic [3:0] b,
                      input logic [31:0] wd, input logic [31:0] exp_rd);
    int waited;
    @(negedge clk);
    chk("idle_dbus_zero", sl_dbus, 32'h0);
    abus = BASE + 32'(idx * 4);
    be   = b;
    dbus = wd;
    rnw  = r;
    sel  = 1'b1;
    sb.push_back(r ? exp_rd : 32'h0);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!xack && waited < 4);
    chk("ack_latency", waited, 1);
    chk("ack_seen", xack, 1'b1);
    sel  = 1'b0;
    rnw  = 1'b0;
    dbus = '0;
    chk("ack_dbus", sl_dbus, sb.pop_front());
  endtask

  // Checks for cycles N+2 (strobe/value) and N+3 (strobe cleared).
  task automatic after_ack(input logic [N-1:0] exp_strb);
    @(negedge clk);
    chk("post_ack_low", xack, 1'b0);
    chk("post_dbus_zero", sl_dbus, 32'h0);
    chk("strb_pulse", strb, exp_strb);
    chk("user_data", udata, pack_model());
    @(negedge clk);
    chk("strb_clear", strb, '0);
  endtask

  initial begin
    logic [8:0] ackv;
    for (int i = 0; i < N; i++) model[i] = RV;
`ifdef OPB_REGBANK_SHADOW_EN
    for (int i = 0; i < N; i++) shadow_m[i] = RV;
`endif
    repeat (3) @(negedge clk);
    chk("rst_ack", xack, 1'b0);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_strb", strb, '0);
    chk("rst_user_data", udata, pack_model());
    chk("rst_ties", {errack, retry, tout}, 3'b000);
    rst = 1'b0;

    // Reset value readback.
    xfer(1'b1, 3, 4'hF, 32'h0, RV); after_ack('0);

`ifdef OPB_REGBANK_SHADOW_EN
    xfer(1'b0, 0, 4'hF, 32'd5, 32'h0); shadow_m[0] = 32'd5; after_ack('0);
    xfer(1'b0, 1, 4'hF, 32'd7, 32'h0); shadow_m[1] = 32'd7; after_ack('0);
    xfer(1'b1, 0, 4'hF, 32'h0, 32'd5); after_ack('0);
    xfer(1'b0, N, 4'hF, 32'h0, 32'h0);
    for (int i = 0; i < N; i++) model[i] = shadow_m[i];
    after_ack('1);
    xfer(1'b1, N, 4'hF, 32'h0, 32'd1); after_ack('0);
    xfer(1'b1, 1, 4'hF, 32'h0, 32'd7); after_ack('0);
`else
    // Full write, readback, then partial byte-lane write.
    xfer(1'b0, 2, 4'b1111, 32'hDEADBEEF, 32'h0); model[2] = 32'hDEADBEEF; after_ack(8'b0000_0100);
    xfer(1'b1, 2, 4'hF, 32'h0, 32'hDEADBEEF); after_ack('0);
    xfer(1'b0, 2, 4'b0101, 32'h11223344, 32'h0); model[2] = 32'hDE22BE44; after_ack(8'b0000_0100);
    xfer(1'b1, 2, 4'hF, 32'h0, 32'hDE22BE44); after_ack('0);
    // Empty byte enables: value kept, strobe still fires.
    xfer(1'b0, 5, 4'b0000, 32'hFFFFFFFF, 32'h0); after_ack(8'b0010_0000);
    xfer(1'b1, 5, 4'hF, 32'h0, RV); after_ack('0);
    // Unmapped indices: acked, no strobe, read zero.
    xfer(1'b0, 9, 4'hF, 32'h12345678, 32'h0); after_ack('0);
    xfer(1'b1, 9, 4'hF, 32'h0, 32'h0); after_ack('0);
    xfer(1'b0, N, 4'hF, 32'h87654321, 32'h0); after_ack('0);
    xfer(1'b1, N, 4'hF, 32'h0, 32'h0); after_ack('0);
`endif

    // Select held for 9 cycles: acks in cycles 1, 4 and 7 only.
    @(negedge clk);
    abus = BASE + 32'd12;
    rnw  = 1'b1;
    sel  = 1'b1;
    repeat (3) sb.push_back(model[3]);
    ackv = '0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (xack) begin
        ackv[c-1] = 1'b1;
        if (sb.size() > 0) chk("burst_dbus", sl_dbus, sb.pop_front());
        else chk("burst_extra_ack", xack, 1'b0);
      end else begin
        chk("burst_gap_dbus", sl_dbus, 32'h0);
      end
    end
    sel = 1'b0;
    rnw = 1'b0;
    chk("burst_ack_pattern", ackv, 9'b001_001_001);
    chk("burst_sb_empty", sb.size(), 0);

    // Reset asserted during the ack of a write aborts it.
    xfer(1'b0, 4, 4'hF, 32'hA5A5A5A5, 32'h0);
    rst = 1'b1;
    #1;
    chk("rst_mid_ack_drop", xack, 1'b0);
    chk("rst_mid_dbus", sl_dbus, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) model[i] = RV;
`ifdef OPB_REGBANK_SHADOW_EN
    for (int i = 0; i < N; i++) shadow_m[i] = RV;
`endif
    @(negedge clk);
    chk("rst_mid_user_data", udata, pack_model());
    chk("rst_mid_strb", strb, '0);
    xfer(1'b1, 4, 4'hF, 32'h0, RV); after_ack('0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
